// File: rtl/data_ram_arb_pkg.sv
// Shared types and encodings for the data RAM arbiter.
package data_ram_arb_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BselW = DataW / 8;

  // RAM control strobes are active-low.
  localparam logic CENABLE  = 1'b0;
  localparam logic CDISABLE = 1'b1;
  localparam logic WENABLE  = 1'b0;
  localparam logic WDISABLE = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  typedef struct packed {
    logic             we;
    logic [AddrW-1:0] addr;
    logic [BselW-1:0] bsel;
    logic [DataW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester and RAM signal bundle; slave is the arbiter side.
interface data_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BSEL_W = DATA_W / 8;

  logic              M0_REQ, M0_WE, M0_GNT, M0_RVALID;
  logic [ADDR_W-1:0] M0_ADDR;
  logic [BSEL_W-1:0] M0_BSEL;
  logic [DATA_W-1:0] M0_WDATA, M0_RDATA;

  logic              M1_REQ, M1_WE, M1_GNT, M1_RVALID;
  logic [ADDR_W-1:0] M1_ADDR;
  logic [BSEL_W-1:0] M1_BSEL;
  logic [DATA_W-1:0] M1_WDATA, M1_RDATA;

  logic              RAM_CEN, RAM_WEN;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [BSEL_W-1:0] RAM_BSEL;
  logic [DATA_W-1:0] RAM_SDATA, RAM_LDATA;

  modport slave (
    input  M0_REQ, M0_WE, M0_ADDR, M0_BSEL, M0_WDATA,
    input  M1_REQ, M1_WE, M1_ADDR, M1_BSEL, M1_WDATA,
    input  RAM_LDATA,
    output M0_GNT, M0_RVALID, M0_RDATA,
    output M1_GNT, M1_RVALID, M1_RDATA,
    output RAM_CEN, RAM_WEN, RAM_ADDR, RAM_BSEL, RAM_SDATA
  );

  modport master (
    output M0_REQ, M0_WE, M0_ADDR, M0_BSEL, M0_WDATA,
    output M1_REQ, M1_WE, M1_ADDR, M1_BSEL, M1_WDATA,
    output RAM_LDATA,
    input  M0_GNT, M0_RVALID, M0_RDATA,
    input  M1_GNT, M1_RVALID, M1_RDATA,
    input  RAM_CEN, RAM_WEN, RAM_ADDR, RAM_BSEL, RAM_SDATA
  );
endinterface

// File: rtl/data_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arbiter2
  import data_ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_winner_i,
  output logic [1:0] gnt_o,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = M0;
    gnt_o    = 2'b00;
    case (req_i)
      2'b01:   winner_o = M0;
      2'b10:   winner_o = M1;
      2'b11:   winner_o = ~last_winner_i;
      default: winner_o = M0;
    endcase
    if (valid_o) gnt_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates M0/M1 onto the single-port data RAM: grant, one access cycle, one response cycle.
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic                CLK,
  input  logic                RST_N,
  data_ram_arbiter_if.slave   bus
);

  localparam int unsigned BSEL_W = DATA_W / 8;

  state_e            state_q, state_d;
  cmd_t              cmd_q;
  logic              owner_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic [1:0]        arb_gnt;
  logic              arb_winner, arb_valid, arb_en, grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [BSEL_W-1:0] win_bsel;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter2 u_arb (
    .req_i         ({bus.M1_REQ, bus.M0_REQ}),
    .last_winner_i (owner_q),
    .gnt_o         (arb_gnt),
    .winner_o      (arb_winner),
    .valid_o       (arb_valid)
  );

  // Gating with RST_N keeps GNT low while reset is held, not just after it.
  assign arb_en = RST_N && (state_q != StAccess);
  assign grant  = arb_en && arb_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StResp: state_d = arb_valid ? StAccess : StIdle;
      StAccess:       state_d = StResp;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    if (arb_winner == M1) begin
      win_we    = bus.M1_WE;
      win_addr  = bus.M1_ADDR;
      win_bsel  = bus.M1_BSEL;
      win_wdata = bus.M1_WDATA;
    end else begin
      win_we    = bus.M0_WE;
      win_addr  = bus.M0_ADDR;
      win_bsel  = bus.M0_BSEL;
      win_wdata = bus.M0_WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      owner_q    <= M1;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        cmd_q   <= '{we: win_we, addr: win_addr, bsel: win_bsel, wdata: win_wdata};
        owner_q <= arb_winner;
      end
      if (state_q == StAccess && !cmd_q.we) begin
        if (owner_q == M1) m1_rdata_q <= bus.RAM_LDATA;
        else               m0_rdata_q <= bus.RAM_LDATA;
      end
    end
  end

  assign bus.M0_GNT    = arb_en && arb_gnt[0];
  assign bus.M1_GNT    = arb_en && arb_gnt[1];
  assign bus.M0_RVALID = (state_q == StResp) && (owner_q == M0);
  assign bus.M1_RVALID = (state_q == StResp) && (owner_q == M1);
  assign bus.M0_RDATA  = m0_rdata_q;
  assign bus.M1_RDATA  = m1_rdata_q;

  // Address/data hold the last command outside ACCESS; only the strobes toggle.
  assign bus.RAM_CEN   = (state_q == StAccess) ? CENABLE : CDISABLE;
  assign bus.RAM_WEN   = (state_q == StAccess && cmd_q.we) ? WENABLE : WDISABLE;
  assign bus.RAM_ADDR  = cmd_q.addr;
  assign bus.RAM_BSEL  = cmd_q.bsel;
  assign bus.RAM_SDATA = cmd_q.wdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed table, hand sequences, random traffic vs a transaction model.
module tb_data_ram_arbiter;
  import data_ram_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NRand = 400;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic preload = 1'b1;
  always #5 CLK = ~CLK;

  data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // Behavioural single-port RAM: combinational read, byte-masked write at the clock edge.
  logic [31:0] ram [16];
  assign bus.RAM_LDATA = ram[bus.RAM_ADDR[5:2]];
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[1] <= 32'h11223344;
      ram[3] <= 32'h55AA55AA;
      ram[4] <= 32'hA0A0A0A0;
      ram[5] <= 32'hB1B1B1B1;
      ram[6] <= 32'hCAFEF00D;
    end else if (bus.RAM_CEN == CENABLE && bus.RAM_WEN == WENABLE) begin
      for (int b = 0; b < 4; b++)
        if (bus.RAM_BSEL[b]) ram[bus.RAM_ADDR[5:2]][8*b +: 8] <= bus.RAM_SDATA[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] bsel,
                         input logic [31:0] wdata);
    if (id == M1) begin
      bus.M1_REQ = req; bus.M1_WE = we; bus.M1_ADDR = addr;
      bus.M1_BSEL = bsel; bus.M1_WDATA = wdata;
    end else begin
      bus.M0_REQ = req; bus.M0_WE = we; bus.M0_ADDR = addr;
      bus.M0_BSEL = bsel; bus.M0_WDATA = wdata;
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        r0, we0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic [1:0]  gnt, rv;
    logic [31:0] rd0, rd1;
    logic        cen, wen;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t row(logic rst, logic r0, logic we0, logic [31:0] a0, logic r1,
                               logic [31:0] a1, logic [1:0] gnt, logic [1:0] rv,
                               logic [31:0] rd0, logic [31:0] rd1, logic cen, logic wen,
                               logic [31:0] addr);
    vec_t v;
    v.rst_n = rst; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.gnt = gnt; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1; v.cen = cen; v.wen = wen;
    v.addr = addr;
    return v;
  endfunction

  // One full transaction by a single requester, checking each of its three cycles.
  task automatic xact(input logic id, input logic we, input logic [31:0] addr,
                      input logic [3:0] bsel, input logic [31:0] wdata,
                      input logic [31:0] exp_rd);
    logic [1:0] onehot;
    onehot = (id == M1) ? 2'b10 : 2'b01;
    @(posedge CLK); #1;
    set_req(id, 1'b1, we, addr, bsel, wdata);
    @(negedge CLK);
    chk("x_gnt", {bus.M1_GNT, bus.M0_GNT}, onehot);
    @(posedge CLK); #1;
    set_req(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    chk("x_cen", bus.RAM_CEN, CENABLE);
    chk("x_wen", bus.RAM_WEN, we ? WENABLE : WDISABLE);
    chk("x_addr", bus.RAM_ADDR, addr);
    chk("x_bsel", bus.RAM_BSEL, bsel);
    if (we) chk("x_sdata", bus.RAM_SDATA, wdata);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("x_rvalid", {bus.M1_RVALID, bus.M0_RVALID}, onehot);
    chk("x_cen_off", bus.RAM_CEN, CDISABLE);
    if (!we) chk("x_rdata", (id == M1) ? bus.M1_RDATA : bus.M0_RDATA, exp_rd);
  endtask

  typedef struct {
    int          due;
    logic        id;
    logic        we;
    logic [31:0] rdata;
  } pend_t;

  vec_t        tbl[$];
  pend_t       pq[$];
  logic [31:0] ref_mem [16];
  logic        p_req [2];
  logic        p_we [2];
  logic [31:0] p_addr [2];
  logic [3:0]  p_bsel [2];
  logic [31:0] p_wdata [2];
  logic [31:0] exp_rd [2];
  logic        last_win;
  int          last_g;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_req(M0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_req(M1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge CLK); #1;
    preload = 1'b0;

    //            rst   r0    we0   a0      r1    a1      gnt    rv     rd0  rd1  cen wen addr
    tbl.push_back(row(1'b0, 1'b1, 1'b1, 'h8, 1'b0, 'h0, 2'b00, 2'b00, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h0));
    tbl.push_back(row(1'b1, 1'b1, 1'b1, 'h8, 1'b0, 'h0, 2'b01, 2'b00, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h0));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b00, 'h0, 'h0,
                      CENABLE, WENABLE, 'h8));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b01, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h8));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h8, 1'b0, 'h0, 2'b01, 2'b00, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h8));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b00, 'h0, 'h0,
                      CENABLE, WDISABLE, 'h8));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b01, 'hDEADBEEF, 'h0,
                      CDISABLE, WDISABLE, 'h8));
    // Reset, then both loads held for six cycles: M0, M1, M0.
    tbl.push_back(row(1'b0, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b00, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h0));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b01, 2'b00, 'h0, 'h0,
                      CDISABLE, WDISABLE, 'h0));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b00, 2'b00, 'h0, 'h0,
                      CENABLE, WDISABLE, 'h10));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b10, 2'b01, 'hA0A0A0A0, 'h0,
                      CDISABLE, WDISABLE, 'h10));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b00, 2'b00, 'hA0A0A0A0, 'h0,
                      CENABLE, WDISABLE, 'h14));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b01, 2'b10, 'hA0A0A0A0,
                      'hB1B1B1B1, CDISABLE, WDISABLE, 'h14));
    tbl.push_back(row(1'b1, 1'b1, 1'b0, 'h10, 1'b1, 'h14, 2'b00, 2'b00, 'hA0A0A0A0,
                      'hB1B1B1B1, CENABLE, WDISABLE, 'h10));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b01, 'hA0A0A0A0,
                      'hB1B1B1B1, CDISABLE, WDISABLE, 'h10));
    tbl.push_back(row(1'b1, 1'b0, 1'b0, 'h0, 1'b0, 'h0, 2'b00, 2'b00, 'hA0A0A0A0,
                      'hB1B1B1B1, CDISABLE, WDISABLE, 'h10));

    foreach (tbl[i]) begin
      @(posedge CLK); #1;
      RST_N = tbl[i].rst_n;
      set_req(M0, tbl[i].r0, tbl[i].we0, tbl[i].a0, 4'hF, 32'hDEADBEEF);
      set_req(M1, tbl[i].r1, 1'b0, tbl[i].a1, 4'hF, 32'h0);
      @(negedge CLK);
      chk($sformatf("t%0d_gnt", i), {bus.M1_GNT, bus.M0_GNT}, tbl[i].gnt);
      chk($sformatf("t%0d_rvalid", i), {bus.M1_RVALID, bus.M0_RVALID}, tbl[i].rv);
      chk($sformatf("t%0d_rdata0", i), bus.M0_RDATA, tbl[i].rd0);
      chk($sformatf("t%0d_rdata1", i), bus.M1_RDATA, tbl[i].rd1);
      chk($sformatf("t%0d_cen", i), bus.RAM_CEN, tbl[i].cen);
      chk($sformatf("t%0d_wen", i), bus.RAM_WEN, tbl[i].wen);
      chk($sformatf("t%0d_addr", i), bus.RAM_ADDR, tbl[i].addr);
    end

    // Partial store, then empty-mask store.
    xact(M1, 1'b1, 32'h4, 4'b0010, 32'h0000AB00, 32'h0);
    xact(M1, 1'b0, 32'h4, 4'hF, 32'h0, 32'h1122AB44);
    xact(M0, 1'b1, 32'hC, 4'b0000, 32'hFFFFFFFF, 32'h0);
    xact(M0, 1'b0, 32'hC, 4'hF, 32'h0, 32'h55AA55AA);

    // Reset lands in the ACCESS cycle of a store.
    @(posedge CLK); #1;
    set_req(M0, 1'b1, 1'b1, 32'h18, 4'hF, 32'h12345678);
    @(negedge CLK);
    chk("rst_gnt_before", {bus.M1_GNT, bus.M0_GNT}, 2'b01);
    @(posedge CLK); #1;
    set_req(M0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_gnt", {bus.M1_GNT, bus.M0_GNT}, 2'b00);
    chk("rst_rvalid", {bus.M1_RVALID, bus.M0_RVALID}, 2'b00);
    chk("rst_cen", bus.RAM_CEN, CDISABLE);
    chk("rst_wen", bus.RAM_WEN, WDISABLE);
    chk("rst_addr", bus.RAM_ADDR, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(negedge CLK);
      chk("rst_no_rvalid", {bus.M1_RVALID, bus.M0_RVALID}, 2'b00);
    end
    xact(M0, 1'b0, 32'h18, 4'hF, 32'h0, 32'hCAFEF00D);

    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("idle_cen", bus.RAM_CEN, CDISABLE);
      chk("idle_gnt", {bus.M1_GNT, bus.M0_GNT}, 2'b00);
      chk("idle_rvalid", {bus.M1_RVALID, bus.M0_RVALID}, 2'b00);
    end

    // Random traffic from a clean reset against the transaction model.
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = ram[i];
    for (int id = 0; id < 2; id++) begin
      p_req[id] = 1'b0; p_we[id] = 1'b0; p_addr[id] = '0; p_bsel[id] = '0;
      p_wdata[id] = '0; exp_rd[id] = '0;
    end
    last_win = M1;
    last_g = -100;

    for (int cyc = 0; cyc < int'(NRand) + 4; cyc++) begin
      logic [1:0] expg, exprv;
      logic       w;
      @(posedge CLK); #1;
      for (int id = 0; id < 2; id++) begin
        if (!p_req[id] && cyc < int'(NRand) && $urandom_range(0, 2) != 0) begin
          p_req[id]   = 1'b1;
          p_we[id]    = 1'($urandom_range(0, 1));
          p_addr[id]  = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
          p_bsel[id]  = 4'($urandom);
          p_wdata[id] = $urandom;
        end
      end
      set_req(M0, p_req[0], p_we[0], p_addr[0], p_bsel[0], p_wdata[0]);
      set_req(M1, p_req[1], p_we[1], p_addr[1], p_bsel[1], p_wdata[1]);
      @(negedge CLK);

      expg = 2'b00;
      w = M0;
      if (cyc - last_g >= 2 && (p_req[0] || p_req[1])) begin
        if (p_req[0] && p_req[1]) w = ~last_win;
        else                      w = p_req[1] ? M1 : M0;
        expg[w] = 1'b1;
      end
      chk("rnd_gnt", {bus.M1_GNT, bus.M0_GNT}, expg);
      chk("rnd_cen", bus.RAM_CEN, (cyc - last_g == 1) ? CENABLE : CDISABLE);

      exprv = 2'b00;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        exprv[pq[0].id] = 1'b1;
        if (!pq[0].we) exp_rd[pq[0].id] = pq[0].rdata;
        void'(pq.pop_front());
      end
      chk("rnd_rvalid", {bus.M1_RVALID, bus.M0_RVALID}, exprv);
      chk("rnd_rdata0", bus.M0_RDATA, exp_rd[0]);
      chk("rnd_rdata1", bus.M1_RDATA, exp_rd[1]);

      if (expg != 2'b00) begin
        pend_t e;
        logic [3:0] idx;
        idx = p_addr[w][5:2];
        e.due = cyc + 2;
        e.id = w;
        e.we = p_we[w];
        e.rdata = ref_mem[idx];
        if (p_we[w])
          for (int b = 0; b < 4; b++)
            if (p_bsel[w][b]) ref_mem[idx][8*b +: 8] = p_wdata[w][8*b +: 8];
        pq.push_back(e);
        last_win = w;
        last_g = cyc;
        p_req[w] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data RAM.
- Requester M0 is the CPU MEM stage; requester M1 is the debug/DMA load-store port.
- Each granted command is latched, issued to the RAM for exactly one cycle, and acknowledged with a one-cycle response pulse to the winner.
- Round-robin fairness; RAM enables are driven only during the access cycle.

Parameters:
ADDR_W, 32, requester and RAM address width (matches the data address bus)
DATA_W, 32, data width; byte-select width is DATA_W/8

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
M0_REQ  in  1  M0 request; held until M0_GNT
M0_WE  in  1  1 = store, 0 = load
M0_ADDR  in  ADDR_W  byte address
M0_BSEL  in  DATA_W/8  byte lane enables for stores
M0_WDATA  in  DATA_W  store data
M0_GNT  out  1  command accepted this cycle
M0_RVALID  out  1  one-cycle completion pulse
M0_RDATA  out  DATA_W  load data, valid with M0_RVALID
M1_*  same set as M0_*, for requester M1
RAM_CEN  out  1  RAM chip enable (codebase CENABLE/CDISABLE encoding)
RAM_WEN  out  1  RAM write enable (codebase WENABLE/WDISABLE encoding)
RAM_ADDR  out  ADDR_W  RAM address
RAM_BSEL  out  DATA_W/8  RAM byte select
RAM_SDATA  out  DATA_W  RAM store data
RAM_LDATA  in  DATA_W  RAM load data; combinational read of RAM_ADDR

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low.
- Reset values:
  - FSM state = IDLE.
  - All GNT and RVALID outputs = 0; RDATA outputs = 0.
  - RAM_CEN = CDISABLE, RAM_WEN = WDISABLE; RAM_ADDR/BSEL/SDATA = 0.
  - last_winner = M1, so M0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration (combinational, evaluated only in IDLE and RESP):
  - Exactly one request: that requester wins.
  - Both requesting: the requester that is not last_winner wins.
  - The winner's GNT is high in that same cycle. Command fields are latched into cmd registers at the clock edge, and last_winner updates.
  - Next state: ACCESS if any request was granted; otherwise IDLE.
- ACCESS (exactly 1 cycle):
  - RAM_CEN = CENABLE.
  - RAM_WEN = WENABLE if cmd.we, else WDISABLE.
  - RAM_ADDR/BSEL/SDATA driven from the cmd registers.
  - Store: RAM commits at the end of this cycle.
  - Load: RAM_LDATA is captured into the winner's RDATA register at the end of this cycle.
  - Always proceeds to RESP.
- RESP:
  - Winner's RVALID = 1 for this single cycle; stores also get RVALID as an ack.
  - Winner's RDATA holds the load value. For stores RDATA is unchanged. RDATA keeps its value until the next load for that requester completes.
  - RAM_CEN = CDISABLE.
  - Arbitration runs again; a grant here goes straight back to ACCESS.
- Latency and throughput: GNT at cycle T, RAM access at T+1, RVALID at T+2. Back-to-back throughput is one access per 2 cycles.
- RAM outputs outside ACCESS: enables deasserted; ADDR/BSEL/SDATA hold their last values. Data RAM contents are untouched.
- Requester protocol: a requester must hold REQ and all command fields stable until GNT. Changes before GNT are allowed but undefined for fairness. A requester may reassert REQ in its own RESP cycle.
- Boundary conditions:
  - Both requesting continuously: strict alternation M0, M1, M0, ...
  - Store with BSEL = 0: full ACCESS/RESP sequence, no bytes written.
  - Address passed through unmodified; word selection and misalignment are the RAM's concern.
  - Reset mid-operation (any state): immediate return to the reset values above. No RVALID is emitted, and an in-flight store is not written if reset precedes the ACCESS clock edge.
  - REQ deasserted in the same cycle as arbitration: not granted.

Decomposition:
- Shared package (data_ram_arb_pkg):
  - typedef state_e {IDLE, ACCESS, RESP}.
  - typedef struct cmd_t {we, addr, bsel, wdata}.
  - Localparam requester IDs M0 = 0, M1 = 1.
  - CENABLE/WENABLE encodings come from the existing defines header.
- One natural sub-module: rr_arbiter2 (combinational round-robin pick of 2 requests with last_winner input).

Test Plan:
- Reset, then M0 store ADDR=0x8, BSEL=4'b1111, WDATA=0xDEADBEEF → M0_GNT at T, RAM_CEN/WEN enabled with ADDR 0x8 at T+1, M0_RVALID at T+2; a later M0 load of 0x8 returns 0xDEADBEEF.
- M0 and M1 load requests both held 6 cycles → grants M0, M1, M0 in alternation, 2 cycles apart; each RVALID only to its winner, with the correct RDATA.
- Partial store by M1 BSEL=4'b0010, WDATA=0x0000AB00 onto word 0x11223344 at ADDR 0x4 → subsequent load returns 0x1122AB44.
- Store with BSEL=0 to a word holding 0x55AA55AA → RVALID still pulses; a reload returns 0x55AA55AA.
- RST_N low during ACCESS of a store of 0x12345678 (asserted before the edge) → GNT, RVALID and RAM enables drop immediately; no RVALID follows; the word keeps its old value.
- Idle for 5 cycles with no requests → RAM_CEN stays CDISABLE; no GNT or RVALID.
